// File: rtl/mips_pkg.sv
// Shared types for the MIPS hazard/forwarding controller: the forwarding-mux encodings,
// the per-stage tag carried alongside each in-flight instruction, and the select helper.
package mips_pkg;

  localparam int MIPS_REG_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [MIPS_REG_W-1:0] rs;
    logic [MIPS_REG_W-1:0] rt;
    logic [MIPS_REG_W-1:0] dst;
    logic                  regwrite;
    logic                  memread;
  } stage_tag_t;

  // MEM is checked first so the youngest producer wins; $0 never forwards.
  function automatic logic [1:0] fwd_select(input stage_tag_t ex_t,
                                            input stage_tag_t mem_t,
                                            input stage_tag_t wb_t,
                                            input logic wb_en,
                                            input logic [MIPS_REG_W-1:0] src);
    if (!ex_t.valid)
      return FWD_REG;
    if (mem_t.valid && mem_t.regwrite && (mem_t.dst != '0) && (mem_t.dst == src))
      return FWD_MEM;
    if (wb_en && wb_t.valid && wb_t.regwrite && (wb_t.dst != '0) && (wb_t.dst == src))
      return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/mips_stage_tag_reg.sv
// One pipeline stage of destination/source tags; a bubble clears the stage on the next edge.
module mips_stage_tag_reg
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_bubble,
  input  stage_tag_t i_tag,
  output stage_tag_t o_tag
);

  stage_tag_t r_tag;

  // NOTE: state is written with <= so every stage samples its neighbour's old value.
  always_ff @(posedge clk) begin
    if (rst || i_bubble)
      r_tag <= '0;
    else
      r_tag <= i_tag;
  end

  assign o_tag = r_tag;

endmodule

// File: rtl/mips_hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS core: EX operand forwarding selects,
// one-cycle load-use stall, taken-branch flush of IF/ID, and saturating event counters.
module mips_hazard_fwd_ctrl
  import mips_pkg::*;
#(
  parameter int REG_W  = MIPS_REG_W,
  parameter int CNT_W  = 16,
  parameter bit WB_FWD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_br_taken,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_tag_t       w_id_tag;
  stage_tag_t       w_ex_tag;
  stage_tag_t       w_mem_tag;
  stage_tag_t       w_wb_tag;
  logic             w_load_hit;
  logic             w_stall;
  logic             w_flush;
  logic             w_ex_bubble;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_id_tag = '{valid:    id_valid,
                      rs:       id_rs,
                      rt:       id_rt,
                      dst:      id_dst,
                      regwrite: id_regwrite,
                      memread:  id_memread};

  assign w_load_hit = w_ex_tag.valid && w_ex_tag.memread && (w_ex_tag.dst != '0) &&
                      ((id_uses_rs && (id_rs == w_ex_tag.dst)) ||
                       (id_uses_rt && (id_rt == w_ex_tag.dst)));

  // Gating with rst keeps the control outputs benign while stale tags are being cleared.
  assign w_stall     = id_valid && w_load_hit && !ex_br_taken && !rst;
  assign w_flush     = ex_br_taken && !rst;
  assign w_ex_bubble = w_stall || ex_br_taken;

  mips_stage_tag_reg u_ex_tag (
    .clk      (clk),
    .rst      (rst),
    .i_bubble (w_ex_bubble),
    .i_tag    (w_id_tag),
    .o_tag    (w_ex_tag)
  );

  mips_stage_tag_reg u_mem_tag (
    .clk      (clk),
    .rst      (rst),
    .i_bubble (1'b0),
    .i_tag    (w_ex_tag),
    .o_tag    (w_mem_tag)
  );

  mips_stage_tag_reg u_wb_tag (
    .clk      (clk),
    .rst      (rst),
    .i_bubble (1'b0),
    .i_tag    (w_mem_tag),
    .o_tag    (w_wb_tag)
  );

  assign fwd_a_sel = rst ? FWD_REG
                         : fwd_select(w_ex_tag, w_mem_tag, w_wb_tag, WB_FWD, w_ex_tag.rs);
  assign fwd_b_sel = rst ? FWD_REG
                         : fwd_select(w_ex_tag, w_mem_tag, w_wb_tag, WB_FWD, w_ex_tag.rt);

  assign pc_write   = !w_stall;
  assign ifid_write = !w_stall;
  assign ifid_flush = w_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_mips_hazard_fwd_ctrl.sv
// Directed bench for mips_hazard_fwd_ctrl: a per-cycle instruction table with hand-derived
// selects/stall/counters, plus reset-during-stall and counter saturation sequences.
module tb_mips_hazard_fwd_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
  } id_t;

  typedef struct packed {
    id_t        id;
    logic       br;
    logic [1:0] ea;    // default instance (WB_FWD=1)
    logic [1:0] eb;
    logic [1:0] ea1;   // second instance (WB_FWD=0)
    logic [1:0] eb1;
    logic       stall;
    logic [7:0] scnt;
    logic [7:0] fcnt;
  } vec_t;

  localparam int NV = 39;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, ex_br_taken;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_a_sel1, fwd_b_sel1;
  logic        pc_write, ifid_write, ifid_flush, pc_write1, ifid_write1, ifid_flush1;
  logic [15:0] stall_cnt, flush_cnt;
  logic [2:0]  stall_cnt1, flush_cnt1;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  mips_hazard_fwd_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_br_taken(ex_br_taken),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  mips_hazard_fwd_ctrl #(.CNT_W(3), .WB_FWD(1'b0)) dut_nowb (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_br_taken(ex_br_taken),
    .fwd_a_sel(fwd_a_sel1), .fwd_b_sel(fwd_b_sel1), .pc_write(pc_write1),
    .ifid_write(ifid_write1), .ifid_flush(ifid_flush1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic id_t f_gen(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic [4:0] dst,
                                input logic rw, input logic mr);
    return '{v:v, rs:rs, rt:rt, urs:urs, urt:urt, dst:dst, rw:rw, mr:mr};
  endfunction

  function automatic id_t f_nop();
    return f_gen(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endfunction

  function automatic id_t f_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst);
    return f_gen(1'b1, rs, rt, 1'b1, 1'b1, dst, 1'b1, 1'b0);
  endfunction

  function automatic id_t f_lw(input logic [4:0] base, input logic [4:0] dst);
    return f_gen(1'b1, base, dst, 1'b1, 1'b0, dst, 1'b1, 1'b1);
  endfunction

  function automatic vec_t row(input id_t id, input logic br, input logic [1:0] ea,
                               input logic [1:0] eb, input logic [1:0] ea1, input logic [1:0] eb1,
                               input logic stall, input logic [7:0] scnt, input logic [7:0] fcnt);
    return '{id:id, br:br, ea:ea, eb:eb, ea1:ea1, eb1:eb1, stall:stall, scnt:scnt, fcnt:fcnt};
  endfunction

  task automatic drive(input id_t id, input logic br);
    id_valid    = id.v;
    id_rs       = id.rs;
    id_rt       = id.rt;
    id_uses_rs  = id.urs;
    id_uses_rt  = id.urt;
    id_dst      = id.dst;
    id_regwrite = id.rw;
    id_memread  = id.mr;
    ex_br_taken = br;
  endtask

  initial begin
    // add $3 -> sub $4,$3,$5 (MEM fwd on A)
    vecs[0]  = row(f_r(1, 2, 3),  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = row(f_r(3, 5, 4),  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = row(f_nop(),       0, 1, 0, 1, 0, 0, 0, 0);
    vecs[3]  = row(f_nop(),       0, 0, 0, 0, 0, 0, 0, 0);
    // add $3 ; nop ; or $6,$7,$3 (WB fwd on B only when WB_FWD=1)
    vecs[4]  = row(f_r(1, 2, 3),  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = row(f_nop(),       0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = row(f_r(7, 3, 6),  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = row(f_nop(),       0, 0, 2, 0, 0, 0, 0, 0);
    vecs[8]  = row(f_nop(),       0, 0, 0, 0, 0, 0, 0, 0);
    // lw $8,0($9) ; add $10,$8,$8 (one stall, then WB fwd on both)
    vecs[9]  = row(f_lw(9, 8),    0, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = row(f_r(8, 8, 10), 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[11] = row(f_r(8, 8, 10), 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[12] = row(f_nop(),       0, 2, 2, 0, 0, 0, 1, 0);
    vecs[13] = row(f_nop(),       0, 0, 0, 0, 0, 0, 1, 0);
    // load-use coinciding with a taken branch: flush wins, no stall counted
    vecs[14] = row(f_lw(9, 8),    0, 0, 0, 0, 0, 0, 1, 0);
    vecs[15] = row(f_r(8, 8, 10), 1, 0, 0, 0, 0, 0, 1, 0);
    vecs[16] = row(f_nop(),       0, 0, 0, 0, 0, 0, 1, 1);
    // $0 as destination never forwards or stalls
    vecs[17] = row(f_r(1, 2, 0),  0, 0, 0, 0, 0, 0, 1, 1);
    vecs[18] = row(f_r(0, 0, 4),  0, 0, 0, 0, 0, 0, 1, 1);
    vecs[19] = row(f_nop(),       0, 0, 0, 0, 0, 0, 1, 1);
    vecs[20] = row(f_lw(9, 0),    0, 0, 0, 0, 0, 0, 1, 1);
    vecs[21] = row(f_r(0, 0, 10), 0, 0, 0, 0, 0, 0, 1, 1);
    vecs[22] = row(f_nop(),       0, 0, 0, 0, 0, 0, 1, 1);
    // two writers of $3: MEM beats WB
    vecs[23] = row(f_r(1, 2, 3),  0, 0, 0, 0, 0, 0, 1, 1);
    vecs[24] = row(f_r(4, 5, 3),  0, 0, 0, 0, 0, 0, 1, 1);
    vecs[25] = row(f_r(3, 3, 6),  0, 0, 0, 0, 0, 0, 1, 1);
    vecs[26] = row(f_nop(),       0, 1, 1, 1, 1, 0, 1, 1);
    // store (no regwrite) is not a forward source
    vecs[27] = row(f_gen(1, 1, 2, 1, 1, 7, 0, 0), 0, 0, 0, 0, 0, 0, 1, 1);
    vecs[28] = row(f_r(7, 7, 11), 0, 0, 0, 0, 0, 0, 1, 1);
    vecs[29] = row(f_nop(),       0, 0, 0, 0, 0, 0, 1, 1);
    // uses_rs gating, then stall through rt only
    vecs[30] = row(f_lw(9, 5),    0, 0, 0, 0, 0, 0, 1, 1);
    vecs[31] = row(f_gen(1, 5, 2, 0, 1, 0, 0, 0), 0, 0, 0, 0, 0, 0, 1, 1);
    vecs[32] = row(f_lw(9, 5),    0, 1, 0, 1, 0, 0, 1, 1);
    vecs[33] = row(f_r(1, 5, 12), 0, 0, 2, 0, 0, 1, 1, 1);
    vecs[34] = row(f_r(1, 5, 12), 0, 0, 0, 0, 0, 0, 2, 1);
    vecs[35] = row(f_nop(),       0, 0, 2, 0, 0, 0, 2, 1);
    // invalid ID instruction never stalls
    vecs[36] = row(f_lw(9, 5),    0, 0, 0, 0, 0, 0, 2, 1);
    vecs[37] = row(f_gen(0, 5, 5, 1, 1, 0, 0, 0), 0, 0, 0, 0, 0, 0, 2, 1);
    vecs[38] = row(f_nop(),       0, 0, 0, 0, 0, 0, 2, 1);

    // Reset: branch asserted meanwhile must still leave outputs benign.
    rst = 1'b1;
    drive(f_nop(), 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check("rst fwd_a", 32'(fwd_a_sel), 32'd0);
    check("rst fwd_b", 32'(fwd_b_sel), 32'd0);
    check("rst pc_write", 32'(pc_write), 32'd1);
    check("rst ifid_write", 32'(ifid_write), 32'd1);
    check("rst ifid_flush", 32'(ifid_flush), 32'd0);
    check("rst stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst flush_cnt", 32'(flush_cnt), 32'd0);
    rst = 1'b0;
    drive(f_nop(), 1'b0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].id, vecs[i].br);
      #1;
      check($sformatf("r%0d fwd_a", i), 32'(fwd_a_sel), 32'(vecs[i].ea));
      check($sformatf("r%0d fwd_b", i), 32'(fwd_b_sel), 32'(vecs[i].eb));
      check($sformatf("r%0d nowb fwd_a", i), 32'(fwd_a_sel1), 32'(vecs[i].ea1));
      check($sformatf("r%0d nowb fwd_b", i), 32'(fwd_b_sel1), 32'(vecs[i].eb1));
      check($sformatf("r%0d pc_write", i), 32'(pc_write), 32'(!vecs[i].stall));
      check($sformatf("r%0d ifid_write", i), 32'(ifid_write), 32'(!vecs[i].stall));
      check($sformatf("r%0d ifid_flush", i), 32'(ifid_flush), 32'(vecs[i].br));
      check($sformatf("r%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].scnt));
      check($sformatf("r%0d flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].fcnt));
    end

    // Reset asserted in the middle of a load-use stall.
    @(negedge clk);
    drive(f_lw(9, 8), 1'b0);
    @(negedge clk);
    drive(f_r(8, 8, 10), 1'b0);
    #1;
    check("pre-rst stall pc_write", 32'(pc_write), 32'd0);
    rst = 1'b1;
    #1;
    check("in-rst pc_write", 32'(pc_write), 32'd1);
    check("in-rst ifid_write", 32'(ifid_write), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst pc_write", 32'(pc_write), 32'd1);
    check("post-rst fwd_a", 32'(fwd_a_sel), 32'd0);
    check("post-rst fwd_b", 32'(fwd_b_sel), 32'd0);
    check("post-rst stall_cnt", 32'(stall_cnt), 32'd0);
    check("post-rst flush_cnt", 32'(flush_cnt), 32'd0);
    check("post-rst nowb stall_cnt", 32'(stall_cnt1), 32'd0);

    // 2^3+3 stalls: the 3-bit counter must pin at 7, the 16-bit one keeps counting.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(f_lw(9, 8), 1'b0);
      @(negedge clk);
      drive(f_r(8, 8, 10), 1'b0);
      #1;
      check($sformatf("sat%0d stall", i), 32'(pc_write), 32'd0);
      @(negedge clk);
      #1;
      check($sformatf("sat%0d stall_cnt", i), 32'(stall_cnt), 32'(i + 1));
      check($sformatf("sat%0d nowb stall_cnt", i), 32'(stall_cnt1), 32'((i + 1 > 7) ? 7 : i + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
